// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory responder: width codes, FSM states
// and width-code decode helpers that match the control unit's encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Access size in bytes; 0 for codes that carry no size.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = 3'd1;
            F3_H, F3_HU: f3_size = 3'd2;
            F3_W:        f3_size = 3'd4;
            default:     f3_size = 3'd0;
        endcase
    endfunction

    // Stores have no unsigned variants; loads accept all five codes.
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !wr;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    // Contiguous lane mask for an access of the given size at lane 0.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_responder_byte_ram.sv
// Single-port word RAM with four byte-enable lanes, synchronous write and
// registered read. Contents are intentionally not reset.
module byte_ram #(
    parameter int ADDR_BITS = 15
) (
    input  logic                 clk,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o
);

    logic [31:0] mem_q [2**ADDR_BITS];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_responder.sv
// Load/store responder: accepts one request at a time, runs one or two RAM
// beats (two when the access straddles a word boundary) and returns
// extended load data with a one-cycle completion pulse.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_split,
    output logic                  rsp_err
);

    localparam int WA = ADDR_WIDTH - 2;

    lsu_state_t            state_q, state_d;
    logic                  write_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           lo_word_q;
    logic                  req_ready_q, rsp_valid_q, rsp_split_q, rsp_err_q;

    logic                  accept_s;
    logic [1:0]            off_s;
    logic [4:0]            sh_s;
    logic [5:0]            sh_inv_s;
    logic [7:0]            lanes_s;
    logic                  split_s;
    logic [WA-1:0]         word_s, word_next_s;
    logic [31:0]           wlo_s, whi_s;
    logic                  ram_en_s;
    logic [3:0]            ram_be_s;
    logic [WA-1:0]         ram_addr_s;
    logic [31:0]           ram_wdata_s, ram_rdata_s;
    logic [31:0]           lo_s, hi_s, raw_s, ext_s;

    assign accept_s    = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign off_s       = addr_q[1:0];
    assign sh_s        = {off_s, 3'b000};
    assign sh_inv_s    = 6'd32 - {1'b0, sh_s};
    assign lanes_s     = {4'b0000, size_mask(f3_size(f3_q))} << off_s;
    assign split_s     = |lanes_s[7:4];
    assign word_s      = addr_q[ADDR_WIDTH-1:2];
    assign word_next_s = word_s + {{(WA-1){1'b0}}, 1'b1};
    // Store data split across the two words; a shift by 32 yields zero.
    assign wlo_s       = wdata_q << sh_s;
    assign whi_s       = wdata_q >> sh_inv_s;

    // Next-state and RAM beat control.
    always_comb begin
        state_d     = state_q;
        ram_en_s    = 1'b0;
        ram_be_s    = 4'b0000;
        ram_addr_s  = word_s;
        ram_wdata_s = wlo_s;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = f3_legal(req_write, req_funct3) ? ST_BEAT1 : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT1: begin
                ram_en_s = 1'b1;
                ram_be_s = lanes_s[3:0];
                state_d  = split_s ? ST_BEAT2 : ST_RESP;
            end
            ST_BEAT2: begin
                ram_en_s    = 1'b1;
                ram_be_s    = lanes_s[7:4];
                ram_addr_s  = word_next_s;
                ram_wdata_s = whi_s;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A beat coinciding with reset must not touch memory.
    byte_ram #(.ADDR_BITS(WA)) u_ram (
        .clk     (clk),
        .en_i    (ram_en_s && !rst),
        .we_i    (write_q),
        .be_i    (ram_be_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // State, request latch, first-beat capture and response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            lo_word_q   <= 32'h0000_0000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_split_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_split_q <= (state_q == ST_BEAT2);
            // Only an illegal accept jumps from IDLE straight to RESP.
            rsp_err_q   <= (state_q == ST_IDLE) && (state_d == ST_RESP);
            if (accept_s) begin
                write_q <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_WIDTH-1:0];
                wdata_q <= req_wdata;
            end
            // During BEAT2 the read register still holds the first word.
            if (state_q == ST_BEAT2) begin
                lo_word_q <= ram_rdata_s;
            end
        end
    end

    // Load assembly: align the (possibly two-word) data to lane 0, then extend.
    always_comb begin
        lo_s  = split_s ? lo_word_q : ram_rdata_s;
        hi_s  = split_s ? ram_rdata_s : 32'h0000_0000;
        raw_s = (lo_s >> sh_s) | (hi_s << sh_inv_s);
        case (f3_q)
            F3_B:    ext_s = {{24{raw_s[7]}}, raw_s[7:0]};
            F3_H:    ext_s = {{16{raw_s[15]}}, raw_s[15:0]};
            F3_W:    ext_s = raw_s;
            F3_BU:   ext_s = {24'h00_0000, raw_s[7:0]};
            F3_HU:   ext_s = {16'h0000, raw_s[15:0]};
            default: ext_s = 32'h0000_0000;
        endcase
        if ((state_q == ST_RESP) && !write_q && !rsp_err_q) begin
            rsp_rdata = ext_s;
        end else begin
            rsp_rdata = 32'h0000_0000;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_split = rsp_split_q;
    assign rsp_err   = rsp_err_q;

endmodule
